// File: rtl/fun_table_if.sv
// fun_table_if
//   Bundles the SRT-4 quotient-digit selection request/response signals.
//   Ports (signals):
//     in_valid  1  b/p valid this cycle            (master -> slave)
//     b         4  divisor estimate 1.b2b1b0       (master -> slave)
//     p         6  signed remainder estimate, 1/8  (master -> slave)
//     q         3  two's-complement quotient digit (slave -> master)
//     q_valid   1  q holds the digit for last b/p  (slave -> master)
interface fun_table_if;
  logic       in_valid;
  logic [3:0] b;
  logic [5:0] p;
  logic [2:0] q;
  logic       q_valid;

  modport master (
    output in_valid, b, p,
    input  q, q_valid
  );

  modport slave (
    input  in_valid, b, p,
    output q, q_valid
  );
endinterface

// File: rtl/fun_table.sv
// fun_table
//   Radix-4 SRT quotient-digit selection (digit set -2..+2). Looks up per-divisor
//   thresholds, compares the signed remainder estimate against them and registers
//   the selected digit once.
//   Ports:
//     clk    in  1  rising-edge clock
//     rst_n  in  1  asynchronous active-low reset
//     bus    slave modport of fun_table_if (in_valid, b, p in; q, q_valid out)
module fun_table (
  input  logic        clk,
  input  logic        rst_n,
  fun_table_if.slave  bus
);

  logic signed [5:0] w_p;
  logic signed [5:0] w_m2;
  logic signed [5:0] w_m1;
  logic signed [5:0] w_m0;
  logic signed [5:0] w_mn1;
  logic [2:0]        w_sel;
  logic [2:0]        r_q;
  logic              r_q_valid;

  assign w_p = $signed(bus.p);

  // Per-divisor thresholds in units of 1/8. All fit in 6-bit signed.
  always_comb begin
    w_m2  = 6'sd0;
    w_m1  = 6'sd0;
    w_m0  = 6'sd0;
    w_mn1 = 6'sd0;
    case (bus.b)
      4'd8:    begin w_m2 = 6'sd12; w_m1 = 6'sd4; w_m0 = -6'sd4; w_mn1 = -6'sd13; end
      4'd9:    begin w_m2 = 6'sd14; w_m1 = 6'sd4; w_m0 = -6'sd6; w_mn1 = -6'sd15; end
      4'd10:   begin w_m2 = 6'sd15; w_m1 = 6'sd4; w_m0 = -6'sd6; w_mn1 = -6'sd16; end
      4'd11:   begin w_m2 = 6'sd16; w_m1 = 6'sd4; w_m0 = -6'sd6; w_mn1 = -6'sd18; end
      4'd12:   begin w_m2 = 6'sd18; w_m1 = 6'sd6; w_m0 = -6'sd8; w_mn1 = -6'sd20; end
      4'd13:   begin w_m2 = 6'sd20; w_m1 = 6'sd6; w_m0 = -6'sd8; w_mn1 = -6'sd20; end
      4'd14:   begin w_m2 = 6'sd20; w_m1 = 6'sd8; w_m0 = -6'sd8; w_mn1 = -6'sd22; end
      4'd15:   begin w_m2 = 6'sd24; w_m1 = 6'sd8; w_m0 = -6'sd8; w_mn1 = -6'sd24; end
      default: begin w_m2 = 6'sd0;  w_m1 = 6'sd0; w_m0 = 6'sd0;  w_mn1 = 6'sd0;  end
    endcase
  end

  // Lower bounds are inclusive. Unnormalized divisors (b[3]=0) force digit 0.
  always_comb begin
    w_sel = 3'b000;
    if (!bus.b[3])        w_sel = 3'b000;
    else if (w_p >= w_m2) w_sel = 3'b010;
    else if (w_p >= w_m1) w_sel = 3'b001;
    else if (w_p >= w_m0) w_sel = 3'b000;
    else if (w_p >= w_mn1) w_sel = 3'b111;
    else                  w_sel = 3'b110;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= 3'b000;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= bus.in_valid;
      if (bus.in_valid) r_q <= w_sel;
    end
  end

  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;

endmodule

// File: tb/tb_fun_table.sv
module tb_fun_table;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fun_table_if bus ();

  fun_table dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference thresholds indexed by b-8, units of 1/8.
  int t_m2 [8] = '{12, 14, 15, 16, 18, 20, 20, 24};
  int t_m1 [8] = '{4, 4, 4, 4, 6, 6, 8, 8};
  int t_m0 [8] = '{-4, -6, -6, -6, -8, -8, -8, -8};
  int t_mn1[8] = '{-13, -15, -16, -18, -20, -20, -22, -24};

  // Digit = -2 plus the number of thresholds the remainder reaches.
  function automatic logic [2:0] model(input logic [3:0] b, input logic [5:0] p);
    int pv;
    int k;
    int d;
    if (b < 4'd8) return 3'b000;
    pv = int'($signed(p));
    k  = int'(b) - 8;
    d  = -2;
    if (pv >= t_mn1[k]) d++;
    if (pv >= t_m0[k])  d++;
    if (pv >= t_m1[k])  d++;
    if (pv >= t_m2[k])  d++;
    return 3'(d);
  endfunction

  task automatic apply(input logic v, input logic [3:0] b, input logic [5:0] p);
    bus.in_valid = v;
    bus.b        = b;
    bus.p        = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 4'd8, 6'd12);
    n_checks++;
    if (bus.q !== 3'b010 || bus.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: q=%b v=%b expected q=010 v=1", bus.q, bus.q_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 3'b000 || bus.q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: q=%b v=%b expected q=000 v=0", bus.q, bus.q_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.q !== 3'b000 || bus.q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: q=%b v=%b expected q=000 v=0", bus.q, bus.q_valid);
    end
    rst_n = 1'b1;
    apply(1'b1, 4'd8, 6'd12);
    n_checks++;
    if (bus.q !== 3'b010 || bus.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: q=%b v=%b expected q=010 v=1", bus.q, bus.q_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] vb [19] = '{8, 8, 8, 8, 8, 8, 8, 8, 15, 15, 15, 15, 15, 15, 15, 8, 8, 15, 15};
    int         vp [19] = '{12, 11, 4, 3, -4, -5, -13, -14, 24, 23, 7, -8, -9, -24, -25,
                            5, -6, 8, -10};
    logic [2:0] vq [19] = '{3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b111, 3'b111, 3'b110,
                            3'b010, 3'b001, 3'b000, 3'b000, 3'b111, 3'b111, 3'b110,
                            3'b001, 3'b111, 3'b001, 3'b111};
    for (int i = 0; i < 19; i++) begin
      apply(1'b1, vb[i], 6'(vp[i]));
      n_checks++;
      if (bus.q !== vq[i] || bus.q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL boundary b=%0d p=%0d: q=%b v=%b expected q=%b v=1",
                 vb[i], vp[i], bus.q, bus.q_valid, vq[i]);
      end
    end
  endtask

  task automatic test_extremes();
    for (int b = 8; b < 16; b++) begin
      apply(1'b1, 4'(b), 6'd31);
      n_checks++;
      if (bus.q !== 3'b010) begin
        n_fail++;
        $display("FAIL extreme_pos b=%0d: q=%b expected 010", b, bus.q);
      end
      apply(1'b1, 4'(b), 6'b100000);
      n_checks++;
      if (bus.q !== 3'b110) begin
        n_fail++;
        $display("FAIL extreme_neg b=%0d: q=%b expected 110", b, bus.q);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] exp_q;
    for (int b = 0; b < 16; b++) begin
      for (int p = 0; p < 64; p++) begin
        exp_q = model(4'(b), 6'(p));
        apply(1'b1, 4'(b), 6'(p));
        n_checks++;
        if (bus.q !== exp_q || bus.q_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL exhaustive b=%0d p=%0d: q=%b v=%b expected q=%b v=1",
                   b, p, bus.q, bus.q_valid, exp_q);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] rb;
    logic [5:0] rp;
    logic       rv;
    logic [2:0] exp_q;
    logic       exp_v;
    exp_q = bus.q;
    for (int i = 0; i < 300; i++) begin
      rb = 4'($urandom_range(0, 15));
      rp = 6'($urandom_range(0, 63));
      rv = 1'($urandom_range(0, 3) != 0);
      exp_v = rv;
      if (rv) exp_q = model(rb, rp);
      apply(rv, rb, rp);
      n_checks++;
      if (bus.q !== exp_q || bus.q_valid !== exp_v) begin
        n_fail++;
        $display("FAIL random b=%0d p=%0d v=%b: q=%b qv=%b expected q=%b qv=%b",
                 rb, rp, rv, bus.q, bus.q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    apply(1'b1, 4'd12, 6'd18);
    n_checks++;
    if (bus.q !== 3'b010 || bus.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_load: q=%b v=%b expected q=010 v=1", bus.q, bus.q_valid);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'($urandom_range(0, 15)), 6'($urandom_range(32, 63)));
      n_checks++;
      if (bus.q !== 3'b010 || bus.q_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: q=%b v=%b expected q=010 v=0", i, bus.q, bus.q_valid);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    bus.in_valid = 1'b0;
    bus.b        = 4'd0;
    bus.p        = 6'd0;
    rst_n        = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 3'b000 || bus.q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL initial_reset: q=%b v=%b expected q=000 v=0", bus.q, bus.q_valid);
    end
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_boundaries();
    test_extremes();
    test_exhaustive();
    test_random();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
